ycbcr2rgb_container: RTL and testbench

YCBCR2RGB_CONTAINER -- requirements
Module: ycbcr2rgb_container

---
 rtl/ycbcr2rgb_container.sv | 153 +++++++++++++++
 tb/tb_ycbcr2rgb_container.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_container.sv
// Block-wise Y/Cb/Cr (signed fixed point) to 8-bit R/G/B converter, CORE_COUNT pixels per cycle.
// Define YCBCR2RGB_ROUND_EN to round half up; otherwise fractional bits are floored.
module ycbcr2rgb_container #(
  parameter int fixed_point_length = 32,
  parameter int frac_bits          = 16,
  parameter int output_width       = 8,
  parameter int PIXEL_COUNT        = 64,
  parameter int CORE_COUNT         = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [fixed_point_length*PIXEL_COUNT-1:0] y_all,
  input  logic [fixed_point_length*PIXEL_COUNT-1:0] cb_all,
  input  logic [fixed_point_length*PIXEL_COUNT-1:0] cr_all,
  output logic [output_width*PIXEL_COUNT-1:0]       r_all,
  output logic [output_width*PIXEL_COUNT-1:0]       g_all,
  output logic [output_width*PIXEL_COUNT-1:0]       b_all,
  output logic                                     busy,
  output logic                                     done,
  output logic [1:0]                               dbg_state_o
);

  localparam int W  = fixed_point_length;
  localparam int F  = frac_bits;
  localparam int OW = output_width;
  localparam int NB = PIXEL_COUNT / CORE_COUNT;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = W + 24;

  localparam logic [CW-1:0]        LAST   = CW'(NB - 1);
  localparam logic signed [IW-1:0] OFFSET = IW'(128) << F;
  localparam logic signed [IW-1:0] K_R    = IW'(91881);
  localparam logic signed [IW-1:0] K_GB   = IW'(22554);
  localparam logic signed [IW-1:0] K_GR   = IW'(46802);
  localparam logic signed [IW-1:0] K_B    = IW'(116130);
  localparam logic signed [IW-1:0] MAXV   = {{(IW-OW){1'b0}}, {OW{1'b1}}};
`ifdef YCBCR2RGB_ROUND_EN
  localparam logic signed [IW-1:0] RND    = IW'(1) << (F + 15);
`else
  localparam logic signed [IW-1:0] RND    = '0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            batch_q, batch_d;
  logic                     done_q, done_d;
  logic [OW*PIXEL_COUNT-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic [OW-1:0] core_r [CORE_COUNT];
  logic [OW-1:0] core_g [CORE_COUNT];
  logic [OW-1:0] core_b [CORE_COUNT];

  function automatic logic [OW-1:0] sat(input logic signed [IW-1:0] v);
    if (v < 0) return '0;
    if (v > MAXV) return '1;
    return v[OW-1:0];
  endfunction

  // Accumulators carry frac_bits+16 fractional bits: Y is pre-shifted to match the Q16 coefficients.
  for (genvar c = 0; c < CORE_COUNT; c++) begin : g_core
    logic [W-1:0]           y_in, cb_in, cr_in;
    logic signed [IW-1:0]   y_s, cb_s, cr_s, dcb, dcr, r_acc, g_acc, b_acc;

    always_comb begin
      y_in  = '0;
      cb_in = '0;
      cr_in = '0;
      if (state_q == RUN) begin
        y_in  = y_all [(int'(batch_q)*CORE_COUNT + c)*W +: W];
        cb_in = cb_all[(int'(batch_q)*CORE_COUNT + c)*W +: W];
        cr_in = cr_all[(int'(batch_q)*CORE_COUNT + c)*W +: W];
      end
      y_s   = {{(IW-W){y_in[W-1]}},  y_in};
      cb_s  = {{(IW-W){cb_in[W-1]}}, cb_in};
      cr_s  = {{(IW-W){cr_in[W-1]}}, cr_in};
      dcb   = cb_s - OFFSET;
      dcr   = cr_s - OFFSET;
      r_acc = (y_s <<< 16) + dcr * K_R + RND;
      g_acc = (y_s <<< 16) - dcb * K_GB - dcr * K_GR + RND;
      b_acc = (y_s <<< 16) + dcb * K_B + RND;
    end

    assign core_r[c] = sat(r_acc >>> (F + 16));
    assign core_g[c] = sat(g_acc >>> (F + 16));
    assign core_b[c] = sat(b_acc >>> (F + 16));
  end

  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          batch_d = '0;
        end
      end
      RUN: begin
        batch_d = batch_q + CW'(1);
        if (batch_q == LAST) begin
          state_d = DONE;
          batch_d = '0;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the current batch's pixels change; everything else holds the previous block.
  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (state_q == RUN) begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        r_d[(int'(batch_q)*CORE_COUNT + c)*OW +: OW] = core_r[c];
        g_d[(int'(batch_q)*CORE_COUNT + c)*OW +: OW] = core_g[c];
        b_d[(int'(batch_q)*CORE_COUNT + c)*OW +: OW] = core_b[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      batch_q <= '0;
      done_q  <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      batch_q <= batch_d;
      done_q  <= done_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign r_all       = r_q;
  assign g_all       = g_q;
  assign b_all       = b_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ycbcr2rgb_container.sv
// Bench for ycbcr2rgb_container: directed blocks plus random blocks against an arithmetic reference.
module tb_ycbcr2rgb_container;

  localparam int W = 32, F = 16, OW = 8, PC = 64, CC = 8;
  localparam int VW = W * PC, OVW = OW * PC;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [VW-1:0]  y_all = '0, cb_all = '0, cr_all = '0;
  logic [OVW-1:0] r_all, g_all, b_all;
  logic           busy, done;
  logic [1:0]     dbg_state;

  int n_checks = 0, n_fail = 0, done_pulses = 0;
  logic [3*OVW-1:0] exp_q[$];
  logic [3*OVW-1:0] last_blk = '0;

  ycbcr2rgb_container #(
    .fixed_point_length(W), .frac_bits(F), .output_width(OW),
    .PIXEL_COUNT(PC), .CORE_COUNT(CC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .y_all(y_all), .cb_all(cb_all), .cr_all(cr_all),
    .r_all(r_all), .g_all(g_all), .b_all(b_all),
    .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: exact Q16 coefficient arithmetic, then floor/round and clamp
  function automatic int to_int(input longint acc);
    longint v;
`ifdef YCBCR2RGB_ROUND_EN
    v = (acc + (longint'(1) <<< (F + 15))) >>> (F + 16);
`else
    v = acc >>> (F + 16);
`endif
    if (v < 0) return 0;
    if (v > longint'((1 << OW) - 1)) return (1 << OW) - 1;
    return int'(v);
  endfunction

  function automatic void model_pix(input longint y, input longint cb, input longint cr,
                                    output int r, output int g, output int b);
    longint dcb, dcr;
    dcb = cb - (longint'(128) <<< F);
    dcr = cr - (longint'(128) <<< F);
    r = to_int((y <<< 16) + 91881 * dcr);
    g = to_int((y <<< 16) - 22554 * dcb - 46802 * dcr);
    b = to_int((y <<< 16) + 116130 * dcb);
  endfunction

  function automatic logic [3*OVW-1:0] model_block();
    logic [3*OVW-1:0] res;
    int r, g, b;
    res = '0;
    for (int p = 0; p < PC; p++) begin
      model_pix(longint'($signed(y_all[p*W +: W])), longint'($signed(cb_all[p*W +: W])),
                longint'($signed(cr_all[p*W +: W])), r, g, b);
      res[2*OVW + p*OW +: OW] = OW'(r);
      res[OVW + p*OW +: OW]   = OW'(g);
      res[p*OW +: OW]         = OW'(b);
    end
    return res;
  endfunction

  // scoreboard: full-block compare on done, hold compare while idle
  always @(negedge clk) begin
    logic [3*OVW-1:0] e;
    if (!rst_n) begin
      last_blk = '0;
    end else if (done) begin
      done_pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        for (int p = 0; p < PC; p++) begin
          check($sformatf("blk_r[%0d]", p), r_all[p*OW +: OW], e[2*OVW + p*OW +: OW]);
          check($sformatf("blk_g[%0d]", p), g_all[p*OW +: OW], e[OVW + p*OW +: OW]);
          check($sformatf("blk_b[%0d]", p), b_all[p*OW +: OW], e[p*OW +: OW]);
        end
        last_blk = e;
      end
    end else if (!busy) begin
      check("hold_r", (r_all == last_blk[2*OVW +: OVW]) ? 1 : 0, 1);
      check("hold_g", (g_all == last_blk[OVW +: OVW]) ? 1 : 0, 1);
      check("hold_b", (b_all == last_blk[0 +: OVW]) ? 1 : 0, 1);
    end
  end

  // driver tasks
  task automatic set_uniform(input logic [W-1:0] y, input logic [W-1:0] cb, input logic [W-1:0] cr);
    for (int p = 0; p < PC; p++) begin
      y_all[p*W +: W]  = y;
      cb_all[p*W +: W] = cb;
      cr_all[p*W +: W] = cr;
    end
  endtask

  task automatic randomize_inputs(input int mode);
    for (int p = 0; p < PC; p++) begin
      if (mode == 0) begin
        y_all[p*W +: W]  = $urandom_range(0, 255 << 16);
        cb_all[p*W +: W] = $urandom_range(0, 255 << 16);
        cr_all[p*W +: W] = $urandom_range(0, 255 << 16);
      end else begin
        y_all[p*W +: W]  = $urandom;
        cb_all[p*W +: W] = $urandom;
        cr_all[p*W +: W] = $urandom;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r_zero"}, (r_all == '0) ? 1 : 0, 1);
    check({tag, "_g_zero"}, (g_all == '0) ? 1 : 0, 1);
    check({tag, "_b_zero"}, (b_all == '0) ? 1 : 0, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // one-cycle start pulse; j counts negedges after the start-sampling edge
  task automatic run_block(input string tag);
    int bc, dj, dc;
    bc = 0; dj = -1; dc = 0;
    exp_q.push_back(model_block());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (busy) bc++;
      if (done) begin dc++; dj = j; end
      if (j < 11) @(negedge clk);
    end
    check({tag, "_busy_cycles"}, bc, 9);
    check({tag, "_done_cycle"}, dj, 8);
    check({tag, "_done_count"}, dc, 1);
  endtask

  function automatic int pix(input logic [OVW-1:0] v, input int p);
    return int'(v[p*OW +: OW]);
  endfunction

  initial begin
    int r, g, b, dj1, dj2, dc, busy9, busy10, pulses0;

    // model pins from hand-worked values
    model_pix(longint'(255) <<< 16, longint'(128) <<< 16, longint'(255) <<< 16, r, g, b);
    check("pin_model_g164", g, 164);
    model_pix(0, 0, longint'(128) <<< 16, r, g, b);
    check("pin_model_g44", g, 44);

    // reset with arbitrary inputs and start requested
    randomize_inputs(1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_all_zero("in_reset");
    start = 1'b0;
    @(negedge clk); #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1 check_all_zero("after_release");

    // gray
    set_uniform(32'h0080_0000, 32'h0080_0000, 32'h0080_0000);
    run_block("gray");
    check("gray_r0", pix(r_all, 0), 128);
    check("gray_g63", pix(g_all, 63), 128);
    check("gray_b31", pix(b_all, 31), 128);

    // ordering
    for (int p = 0; p < PC; p++) begin
      y_all[p*W +: W]  = W'(p << 16);
      cb_all[p*W +: W] = 32'h0080_0000;
      cr_all[p*W +: W] = 32'h0080_0000;
    end
    run_block("order");
    check("order_r0", pix(r_all, 0), 0);
    check("order_g9", pix(g_all, 9), 9);
    check("order_b40", pix(b_all, 40), 40);
    check("order_r63", pix(r_all, 63), 63);

    // clamping
    set_uniform(32'h00FF_0000, 32'h0080_0000, 32'h00FF_0000);
    run_block("clamp_hi");
    check("clamp_hi_r", pix(r_all, 5), 255);
    check("clamp_hi_g", pix(g_all, 5), 164);
    check("clamp_hi_b", pix(b_all, 5), 255);
    set_uniform(32'h0000_0000, 32'h0000_0000, 32'h0080_0000);
    run_block("clamp_lo");
    check("clamp_lo_r", pix(r_all, 60), 0);
    check("clamp_lo_g", pix(g_all, 60), 44);
    check("clamp_lo_b", pix(b_all, 60), 0);

    // half-way fraction
    set_uniform(32'h0064_8000, 32'h0080_0000, 32'h0080_0000);
    run_block("half");
`ifdef YCBCR2RGB_ROUND_EN
    check("half_r", pix(r_all, 17), 101);
    check("half_b", pix(b_all, 17), 101);
`else
    check("half_r", pix(r_all, 17), 100);
    check("half_b", pix(b_all, 17), 100);
`endif

    // start held high: one block, then re-accepted exactly on return to IDLE
    randomize_inputs(0);
    exp_q.push_back(model_block());
    exp_q.push_back(model_block());
    dj1 = -1; dj2 = -1; dc = 0; busy9 = -1; busy10 = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 22; j++) begin
      if (done) begin
        dc++;
        if (dj1 < 0) dj1 = j; else dj2 = j;
      end
      if (j == 9) busy9 = busy;
      if (j == 10) begin busy10 = busy; start = 1'b0; end
      if (j < 21) @(negedge clk);
    end
    check("held_busy_at_idle", busy9, 0);
    check("held_busy_reaccept", busy10, 1);
    check("held_first_done", dj1, 8);
    check("held_second_done", dj2, 18);
    check("held_done_count", dc, 2);

    // reset pulse mid-run
    randomize_inputs(0);
    exp_q.push_back(model_block());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrun_rst");
    exp_q.delete();
    pulses0 = done_pulses;
    @(negedge clk); #3 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrun_no_done", done_pulses - pulses0, 0);
    #1 check_all_zero("midrun_after");
    run_block("after_rst");

    // random blocks
    for (int k = 0; k < 16; k++) begin
      randomize_inputs(k % 3 == 2 ? 1 : 0);
      run_block($sformatf("rand%0d", k));
    end

    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
